// File: rtl/direction_input.sv
// Push-button front end: synchronises and debounces four active-low keys, then emits one
// single-cycle one-hot move pulse per physical press, held back until the controller is ready.
module direction_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned GAP_CYCLES      = 4,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] keys_n,
   input  logic       ready,
   output logic [3:0] direction,
   output logic [3:0] key_state,
   output logic       busy
);

   localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StPend, StHold, StGap} state_e;

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       sync;
   logic [CNT_W-1:0] deb_cnt_q [4];
   logic [CNT_W-1:0] deb_cnt_d [4];
   logic [3:0]       key_state_q, key_state_d;
   state_e           state_q;
   logic [3:0]       code_q;
   logic [3:0]       dir_q;
   logic             busy_q;
   logic [CNT_W-1:0] gap_cnt_q;
   logic             one_hot;

   // Synchronisers reset to the released (high) level.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
      end else begin
         sync1_q <= keys_n;
         sync2_q <= sync1_q;
      end
   end

   assign sync = ~sync2_q;

   always_comb begin
      key_state_d = key_state_q;
      deb_cnt_d   = deb_cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync[i] != key_state_q[i]) begin
            if (deb_cnt_q[i] == DebLast) begin
               key_state_d[i] = ~key_state_q[i];
               deb_cnt_d[i]   = '0;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
            end
         end else begin
            deb_cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         key_state_q <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         key_state_q <= key_state_d;
         deb_cnt_q   <= deb_cnt_d;
      end
   end

   assign one_hot = (key_state_q != 4'd0) && ((key_state_q & (key_state_q - 4'd1)) == 4'd0);

   // Pulse default is zero every cycle, so direction can never be a level.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         code_q    <= '0;
         dir_q     <= '0;
         busy_q    <= 1'b0;
         gap_cnt_q <= '0;
      end else begin
         dir_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (key_state_q != 4'd0) begin
                  busy_q <= 1'b1;
                  if (!one_hot) begin
                     state_q <= StHold;
                  end else if (ready) begin
                     dir_q   <= key_state_q;
                     state_q <= StHold;
                  end else begin
                     code_q  <= key_state_q;
                     state_q <= StPend;
                  end
               end
            end
            StPend: begin
               if (ready) begin
                  dir_q   <= code_q;
                  state_q <= StHold;
               end
            end
            StHold: begin
               if (key_state_q == 4'd0) begin
                  gap_cnt_q <= GapLast;
                  state_q   <= StGap;
               end
            end
            StGap: begin
               if (key_state_q != 4'd0) begin
                  state_q <= StHold;
               end else if (gap_cnt_q == '0) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  gap_cnt_q <= gap_cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign direction = dir_q;
   assign key_state = key_state_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
module tb_direction_input;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] keys_n;
   logic       ready;
   logic [3:0] direction;
   logic [3:0] key_state;
   logic       busy;

   int total = 0;
   int bad   = 0;

   direction_input #(
      .DEBOUNCE_CYCLES(4),
      .GAP_CYCLES     (2),
      .CNT_W          (16)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .keys_n   (keys_n),
      .ready    (ready),
      .direction(direction),
      .key_state(key_state),
      .busy     (busy)
   );

   always #5 clock = ~clock;

   // One posedge, then settle; inputs are changed and outputs sampled here.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      keys_n = 4'hF;
      for (int i = 0; i < 14; i++) step();
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      keys_n = 4'hF;
      ready  = 1'b1;
      step();
      step();
      reset = 1'b0;
      total++;
      if (direction !== 4'h0 || key_state !== 4'h0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset dir=%h ks=%h busy=%b required 0/0/0", direction, key_state, busy);
      end
   endtask

   task automatic test_latency();
      int early;
      early  = 0;
      keys_n = 4'b1110;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (direction !== 4'h0) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL latency_early pulses=%0d required 0", early);
      end
      total++;
      if (key_state !== 4'b0001) begin
         bad++;
         $display("FAIL latency_keystate got=%h required 1", key_state);
      end
      step();
      total++;
      if (direction !== 4'b0001 || busy !== 1'b1) begin
         bad++;
         $display("FAIL latency_pulse dir=%h busy=%b required 1/1", direction, busy);
      end
      early = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (direction !== 4'h0 || busy !== 1'b1) early++;
      end
      total++;
      if (early != 0) begin
         bad++;
         $display("FAIL hold_quiet bad_cycles=%0d required 0", early);
      end
      keys_n = 4'hF;
      // Release path: 2 sync + 4 debounce + 1 HOLD->GAP + 2 gap cycles.
      for (int k = 0; k < 8; k++) step();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL gap_busy got=%b required 1", busy);
      end
      step();
      total++;
      if (busy !== 1'b0 || key_state !== 4'h0) begin
         bad++;
         $display("FAIL gap_idle busy=%b ks=%h required 0/0", busy, key_state);
      end
   endtask

   task automatic test_bounce();
      int seen;
      seen   = 0;
      keys_n = 4'b0111;
      for (int k = 0; k < 3; k++) step();
      keys_n = 4'hF;
      for (int k = 0; k < 20; k++) begin
         step();
         if (key_state !== 4'h0 || direction !== 4'h0 || busy !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL bounce bad_cycles=%0d required 0", seen);
      end
   endtask

   task automatic test_pend();
      int seen;
      seen   = 0;
      ready  = 1'b0;
      keys_n = 4'b0111;
      for (int k = 0; k < 20; k++) begin
         if (k == 10) keys_n = 4'hF;
         step();
         if (direction !== 4'h0) seen++;
      end
      total++;
      if (seen != 0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pend_wait pulses=%0d busy=%b required 0/1", seen, busy);
      end
      ready = 1'b1;
      step();
      total++;
      if (direction !== 4'b1000) begin
         bad++;
         $display("FAIL pend_fire got=%h required 8", direction);
      end
      step();
      total++;
      if (direction !== 4'h0) begin
         bad++;
         $display("FAIL pend_single got=%h required 0", direction);
      end
      drain();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL pend_drain busy=%b required 0", busy);
      end
   endtask

   task automatic test_chord();
      int seen;
      seen   = 0;
      ready  = 1'b1;
      keys_n = 4'b1100;
      for (int k = 0; k < 12; k++) begin
         step();
         if (direction !== 4'h0) seen++;
      end
      total++;
      if (seen != 0 || busy !== 1'b1 || key_state !== 4'b0011) begin
         bad++;
         $display("FAIL chord pulses=%0d busy=%b ks=%h required 0/1/3", seen, busy, key_state);
      end
      drain();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL chord_drain busy=%b required 0", busy);
      end
      keys_n = 4'b1101;
      for (int k = 0; k < 7; k++) step();
      total++;
      if (direction !== 4'b0010) begin
         bad++;
         $display("FAIL chord_then_right got=%h required 2", direction);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int good;
      int other;
      good   = 0;
      other  = 0;
      keys_n = 4'b1101;
      for (int k = 0; k < 200; k++) begin
         ready = ~ready;
         step();
         if (direction === 4'b0010) good++;
         else if (direction !== 4'h0) other++;
      end
      total++;
      if (good != 1 || other != 0) begin
         bad++;
         $display("FAIL toggle_ready pulses=%0d other=%0d required 1/0", good, other);
      end
      drain();
   endtask

   task automatic test_reset_in_pend();
      int seen;
      seen   = 0;
      ready  = 1'b0;
      keys_n = 4'b1011;
      for (int k = 0; k < 8; k++) step();
      total++;
      if (busy !== 1'b1 || direction !== 4'h0) begin
         bad++;
         $display("FAIL pend_entry busy=%b dir=%h required 1/0", busy, direction);
      end
      reset  = 1'b1;
      keys_n = 4'hF;
      step();
      reset = 1'b0;
      total++;
      if (direction !== 4'h0 || busy !== 1'b0 || key_state !== 4'h0) begin
         bad++;
         $display("FAIL reset_pend dir=%h busy=%b ks=%h required 0/0/0", direction, busy,
                  key_state);
      end
      ready = 1'b1;
      for (int k = 0; k < 15; k++) begin
         step();
         if (direction !== 4'h0 || busy !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL reset_pend_lost bad_cycles=%0d required 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_bounce();
      test_pend();
      test_chord();
      test_back_to_back();
      test_reset_in_pend();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
